// File: rtl/pwr_gate_seq_pkg.sv
// Shared definitions for the power-domain sequencer.
//   state_e    : sequencer states with fixed observation encodings
//   STATE_W    : width of the observable state code
//   FAULT_CODE : encoding reserved for the sticky fault state
//   is_busy()  : 1 for every transitional state (not ON, OFF or FAULT)
package pwr_gate_seq_pkg;

  localparam int STATE_W = 4;
  localparam logic [STATE_W-1:0] FAULT_CODE = 4'd15;

  typedef enum logic [STATE_W-1:0] {
    ST_ON      = 4'd0,
    ST_CLKOFF  = 4'd1,
    ST_ISO     = 4'd2,
    ST_SAVE    = 4'd3,
    ST_PDOWN   = 4'd4,
    ST_OFF     = 4'd5,
    ST_PUP     = 4'd6,
    ST_RESTORE = 4'd7,
    ST_DEISO   = 4'd8,
    ST_CLKON   = 4'd9,
    ST_FAULT   = FAULT_CODE
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !(s inside {ST_ON, ST_OFF, ST_FAULT});
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Saturating wait counter shared by all timed sequencer states.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   clear    : restart from 0 (state entry); dominates enable
//   enable   : count up one per cycle, holding at all-ones
//   terminal : wait length in cycles supplied by the FSM (>= 1)
//   count    : current count, 0 in the first cycle after clear
//   hit      : 1 in the terminal-th cycle after clear (count == terminal-1)
module pwr_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic [CNT_W-1:0] count,
  output logic             hit
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign hit = (count == (terminal - CNT_W'(1)));

endmodule

// File: rtl/pwr_gate_seq.sv
// Power-gating sequencer for one switchable domain.
// Orders clock gating, isolation, retention save, rail off, rail on,
// retention restore and de-isolation, with a request/ack handshake to the
// header switch chain and a sticky fault on ack timeout.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset (returns to ON)
//   sleep_req : level request to power down (sampled in ON only)
//   wake_req  : level request to power up (sampled in OFF only)
//   pwr_ack   : switch-chain status, 1 = rail up
//   pwr_en    : header switch enable      iso_en  : isolation clamp enable
//   clk_en    : domain clock-gate enable  save    : retention save pulse
//   restore   : retention restore pulse   busy    : in a transitional state
//   err       : sticky fault flag         state   : current state code
// Build option: define PWR_GATE_SEQ_RETENTION_EN to include the SAVE and
// RESTORE steps; without it save/restore stay 0 and those states are skipped.
module pwr_gate_seq
  import pwr_gate_seq_pkg::*;
#(
  parameter int unsigned ISO_SETUP   = 2,
  parameter int unsigned ACK_TIMEOUT = 200,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sleep_req,
  input  logic               wake_req,
  input  logic               pwr_ack,
  output logic               pwr_en,
  output logic               iso_en,
  output logic               clk_en,
  output logic               save,
  output logic               restore,
  output logic               busy,
  output logic               err,
  output logic [STATE_W-1:0] state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt, term;
  logic             hit, cnt_clr, cnt_en, deiso_last;
  logic             pwr_en_d, iso_en_d, clk_en_d, save_d, restore_d, err_d;

  pwr_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clr),
    .enable   (cnt_en),
    .terminal (term),
    .count    (cnt),
    .hit      (hit)
  );

  // NOTE: every variable written here gets a default first, so no path
  // through the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    term    = CNT_W'(ISO_SETUP);
    cnt_en  = 1'b0;

    case (state_q)
      ST_ON:     if (sleep_req) state_d = ST_CLKOFF;
      ST_CLKOFF: state_d = ST_ISO;
      ST_ISO: begin
        cnt_en = 1'b1;
        if (hit) begin
`ifdef PWR_GATE_SEQ_RETENTION_EN
          state_d = ST_SAVE;
`else
          state_d = ST_PDOWN;
`endif
        end
      end
`ifdef PWR_GATE_SEQ_RETENTION_EN
      ST_SAVE:    state_d = ST_PDOWN;
      ST_RESTORE: state_d = ST_DEISO;
`endif
      ST_PDOWN: begin
        term   = CNT_W'(ACK_TIMEOUT);
        cnt_en = 1'b1;
        // A rail-down ack in the terminal cycle still counts as on time.
        if (!pwr_ack)  state_d = ST_OFF;
        else if (hit)  state_d = ST_FAULT;
      end
      ST_OFF: if (wake_req) state_d = ST_PUP;
      ST_PUP: begin
        term   = CNT_W'(ACK_TIMEOUT);
        cnt_en = 1'b1;
        if (pwr_ack) begin
`ifdef PWR_GATE_SEQ_RETENTION_EN
          state_d = ST_RESTORE;
`else
          state_d = ST_DEISO;
`endif
        end else if (hit) begin
          state_d = ST_FAULT;
        end
      end
      ST_DEISO: begin
        cnt_en = 1'b1;
        if (hit) state_d = ST_CLKON;
      end
      ST_CLKON: state_d = ST_ON;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_FAULT;
    endcase

    cnt_clr = (state_d != state_q);

    // Outputs are registered from the next state, so the clamp release has
    // to be predicted: it drops for the cycle in which the counter will read
    // ISO_SETUP-1, i.e. the final DEISO cycle.
    deiso_last = (state_q == ST_DEISO) ? (cnt == CNT_W'(ISO_SETUP - 2))
                                       : (ISO_SETUP == 1);

    pwr_en_d  = 1'b1;
    iso_en_d  = 1'b1;
    clk_en_d  = 1'b0;
    save_d    = 1'b0;
    restore_d = 1'b0;
    err_d     = 1'b0;
    case (state_d)
      ST_ON, ST_CLKON: begin
        iso_en_d = 1'b0;
        clk_en_d = 1'b1;
      end
      ST_CLKOFF:         iso_en_d = 1'b0;
`ifdef PWR_GATE_SEQ_RETENTION_EN
      ST_SAVE:           save_d    = 1'b1;
      ST_RESTORE:        restore_d = 1'b1;
`endif
      ST_PDOWN, ST_OFF:  pwr_en_d = 1'b0;
      ST_DEISO:          iso_en_d = !deiso_last;
      ST_FAULT:          err_d    = 1'b1;
      default:           ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ON;
      pwr_en  <= 1'b1;
      iso_en  <= 1'b0;
      clk_en  <= 1'b1;
      save    <= 1'b0;
      restore <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pwr_en  <= pwr_en_d;
      iso_en  <= iso_en_d;
      clk_en  <= clk_en_d;
      save    <= save_d;
      restore <= restore_d;
      busy    <= is_busy(state_d);
      err     <= err_d;
    end
  end

  assign state = state_q;

  // Ordering invariants; reset is allowed to drop the clamp immediately.
  a_pwr_fall: assert property (@(posedge clk) disable iff (rst)
    ($fell(pwr_en) && !$past(rst)) |-> (iso_en && !clk_en));
  a_iso_fall: assert property (@(posedge clk) disable iff (rst)
    ($fell(iso_en) && !$past(rst)) |-> (pwr_en && pwr_ack));
  a_save_restore: assert property (@(posedge clk) disable iff (rst)
    !(save && restore));

endmodule

// File: tb/tb_pwr_gate_seq.sv
// Directed bench for pwr_gate_seq (ISO_SETUP=2, ACK_TIMEOUT=10).
// Works for either setting of PWR_GATE_SEQ_RETENTION_EN.
module tb_pwr_gate_seq;

  logic       clk = 1'b0;
  logic       rst, sleep_req, wake_req, pwr_ack;
  logic       pwr_en, iso_en, clk_en, save, restore, busy, err;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int save_cycles = 0;
  int restore_cycles = 0;
  logic [15:0] seen_mask = '0;

`ifdef PWR_GATE_SEQ_RETENTION_EN
  localparam int EXP_SAVE = 4;
  localparam int EXP_RESTORE = 2;
  localparam logic EXP_SEEN = 1'b1;
`else
  localparam int EXP_SAVE = 0;
  localparam int EXP_RESTORE = 0;
  localparam logic EXP_SEEN = 1'b0;
`endif

  pwr_gate_seq #(.ISO_SETUP(2), .ACK_TIMEOUT(10), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sleep_req (sleep_req),
    .wake_req  (wake_req),
    .pwr_ack   (pwr_ack),
    .pwr_en    (pwr_en),
    .iso_en    (iso_en),
    .clk_en    (clk_en),
    .save      (save),
    .restore   (restore),
    .busy      (busy),
    .err       (err),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (save === 1'b1) save_cycles++;
    if (restore === 1'b1) restore_cycles++;
    if (!$isunknown(state)) seen_mask[state] = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // From ON: request sleep and walk to the first PDOWN cycle.
  task automatic sleep_to_pdown(input string t, input bit hold);
    sleep_req = 1'b1;
    step(1);
    check({t, "_clkoff_st"}, state, 1);
    check({t, "_clkoff_clk"}, clk_en, 0);
    check({t, "_clkoff_busy"}, busy, 1);
    if (!hold) sleep_req = 1'b0;
    step(1);
    check({t, "_iso_st"}, state, 2);
    check({t, "_iso_before_pwr"}, {iso_en, pwr_en}, 2'b11);
    step(1);
    check({t, "_iso2_st"}, state, 2);
`ifdef PWR_GATE_SEQ_RETENTION_EN
    step(1);
    check({t, "_save_st"}, state, 3);
    check({t, "_save_pulse"}, save, 1);
`endif
    step(1);
    check({t, "_pdown_st"}, state, 4);
    check({t, "_pdown_outs"}, {pwr_en, iso_en, clk_en, save}, 4'b0100);
  endtask

  // Called with pwr_ack just raised in PUP: walk back to ON.
  task automatic wake_tail(input string t);
    step(1);
`ifdef PWR_GATE_SEQ_RETENTION_EN
    check({t, "_restore_st"}, state, 7);
    check({t, "_restore_pulse"}, {restore, iso_en}, 2'b11);
    step(1);
`endif
    check({t, "_deiso_st"}, state, 8);
    check({t, "_deiso_iso"}, {iso_en, restore}, 2'b10);
    step(1);
    check({t, "_deiso_last"}, {state, iso_en, pwr_en}, {4'd8, 1'b0, 1'b1});
    step(1);
    check({t, "_clkon"}, {state, clk_en, iso_en}, {4'd9, 1'b1, 1'b0});
    step(1);
    check({t, "_on"}, {state, busy, clk_en, pwr_en}, {4'd0, 1'b0, 1'b1, 1'b1});
  endtask

  initial begin
    rst = 1'b1; sleep_req = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1;

    // 1: reset
    step(3);
    rst = 1'b0;
    check("rst_state", state, 0);
    check("rst_outs", {pwr_en, iso_en, clk_en, save, restore, busy, err}, 7'b1010000);
    step(1);
    check("idle_on", state, 0);

    // 2: full sleep, ack falls 3 cycles after pwr_en falls
    sleep_to_pdown("t2", 1'b0);
    step(3);
    check("t2_pdown_wait", state, 4);
    pwr_ack = 1'b0;
    step(1);
    check("t2_off_st", state, 5);
    check("t2_off_outs", {pwr_en, iso_en, clk_en, busy}, 4'b0100);
    sleep_req = 1'b1;
    step(2);
    check("t2_off_ignore_sleep", state, 5);
    sleep_req = 1'b0;

    // 3: wake, ack rises 4 cycles after pwr_en rises
    wake_req = 1'b1;
    step(1);
    check("t3_pup_st", state, 6);
    check("t3_pup_outs", {pwr_en, iso_en, busy}, 3'b111);
    wake_req = 1'b0;
    step(4);
    check("t3_pup_wait", state, 6);
    pwr_ack = 1'b1;
    wake_tail("t3");

    // 4: ack never falls in PDOWN -> fault on cycle 10
    sleep_to_pdown("t4", 1'b0);
    step(9);
    check("t4_last_pdown", state, 4);
    step(1);
    check("t4_fault_st", state, 15);
    check("t4_fault_outs", {err, pwr_en, iso_en, clk_en, busy}, 5'b11100);
    sleep_req = 1'b1; wake_req = 1'b1; pwr_ack = 1'b0;
    step(5);
    check("t4_fault_sticky", {state, err}, {4'd15, 1'b1});
    sleep_req = 1'b0; wake_req = 1'b0; pwr_ack = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t4_rst_clears", {state, err}, {4'd0, 1'b0});

    // 5: both requests high; immediate ack; ack on the 10th PUP cycle
    wake_req = 1'b1;
    sleep_to_pdown("t5", 1'b1);
    pwr_ack = 1'b0;
    step(1);
    check("t5_min_latency_off", state, 5);
    step(1);
    check("t5_off_takes_wake", state, 6);
    sleep_req = 1'b0; wake_req = 1'b0;
    step(9);
    check("t5_pup_last_cycle", state, 6);
    pwr_ack = 1'b1;
    wake_tail("t5");
    step(1);
    check("t5_stays_on", state, 0);

    // 6: reset mid power-down
    sleep_to_pdown("t6", 1'b0);
    step(1);
    check("t6_pdown", state, 4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t6_rst_state", state, 0);
    check("t6_rst_outs", {pwr_en, iso_en, clk_en, busy, err}, 5'b10100);

    // Retention build option
    step(1);
    check("save_cycles", save_cycles, EXP_SAVE);
    check("restore_cycles", restore_cycles, EXP_RESTORE);
    check("seen_state3", seen_mask[3], EXP_SEEN);
    check("seen_state7", seen_mask[7], EXP_SEEN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
